cr_fifo_push_arb: RTL and testbench

Single-clock round-robin arbiter that shares the push port of a FIFO controller between several requesters. It sits in the push clock domain in front of a FIFO controller. It grants one requester at a time a burst of up to `pMaxBurst` words and forwards that requester's data and push strobe to the FIFO. It gates every transfer on the FIFO full flag, so an overrun can never be issued.

---
 rtl/cr_fifo_push_arb.sv | 157 +++++++++++++++
 tb/tb_cr_fifo_push_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cr_fifo_push_arb.sv
`default_nettype none
// ============================================================================
// Module   : cr_fifo_push_arb
// Purpose  : Round-robin arbiter sharing one FIFO push port between several
//            requesters. A winner receives a burst of up to pMaxBurst words.
//            Every transfer is gated on the FIFO full flag, so the FIFO is
//            never overrun.
// Ports    : Clk, Rst_n              - clock, async active-low reset
//            ReqValid/ReqLast/ReqData - per-requester word, last flag, data
//            ReqReady                 - per-requester accept
//            PushFull                 - FIFO full flag (used same cycle)
//            PushReq_n/PushData       - FIFO push strobe (active low), data
//            Grant                    - registered one-hot grant
//            Busy                     - arbiter is in a burst
// Revision : 1.0 - initial release
// ============================================================================
module cr_fifo_push_arb #(
  parameter int pNumReq    = 4,
  parameter int pDataWidth = 8,
  parameter int pMaxBurst  = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [pNumReq-1:0]            ReqValid,
  input  logic [pNumReq-1:0]            ReqLast,
  input  logic [pNumReq*pDataWidth-1:0] ReqData,
  output logic [pNumReq-1:0]            ReqReady,
  input  logic                          PushFull,
  output logic                          PushReq_n,
  output logic [pDataWidth-1:0]         PushData,
  output logic [pNumReq-1:0]            Grant,
  output logic                          Busy
);

  localparam int IW = $clog2(pNumReq);
  localparam int CW = $clog2(pMaxBurst + 1);
  localparam logic [CW-1:0] c_max_burst = CW'(pMaxBurst);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_q, state_nxt;
  logic [pNumReq-1:0]   grant_q, grant_nxt;
  logic [IW-1:0]        last_grant_q, last_grant_nxt;
  logic [CW-1:0]        burst_cnt_q, burst_cnt_nxt;

  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        grant_idx;
  logic                 valid_g;
  logic                 last_g;
  logic                 xfer;
  logic [CW-1:0]        cnt_inc;
  logic [pDataWidth-1:0] data_mux;

  // Rotating priority search: start just after the last served requester so
  // it gets the lowest priority this round.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= pNumReq; k++) begin
      cand = (int'(last_grant_q) + k) % pNumReq;
      if (!win_found && ReqValid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // One-hot grant to index (needed only for LastGrant bookkeeping).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < pNumReq; i++) begin
      if (grant_q[i]) grant_idx = grant_idx | IW'(i);
    end
  end

  // Datapath mux is a plain AND-OR over the one-hot grant; with no grant
  // held it naturally produces zero.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < pNumReq; i++) begin
      data_mux = data_mux | (ReqData[i*pDataWidth +: pDataWidth] & {pDataWidth{grant_q[i]}});
    end
  end

  assign valid_g = |(ReqValid & grant_q);
  assign last_g  = |(ReqLast & grant_q);
  assign xfer    = (state_q == ST_BURST) & valid_g & ~PushFull;
  assign cnt_inc = burst_cnt_q + CW'(1);

  // Next-state logic
  always_comb begin
    state_nxt      = state_q;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant_q;
    burst_cnt_nxt  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !PushFull) begin
          state_nxt     = ST_BURST;
          grant_nxt     = {{(pNumReq-1){1'b0}}, 1'b1} << win_idx;
          burst_cnt_nxt = '0;
        end
      end
      ST_BURST: begin
        // A dropped valid ends the burst without a transfer; a full FIFO
        // simply stalls with everything held.
        if (!valid_g) begin
          state_nxt      = ST_IDLE;
          grant_nxt      = '0;
          last_grant_nxt = grant_idx;
          burst_cnt_nxt  = '0;
        end else if (xfer) begin
          burst_cnt_nxt = cnt_inc;
          if (last_g || (cnt_inc == c_max_burst)) begin
            state_nxt      = ST_IDLE;
            grant_nxt      = '0;
            last_grant_nxt = grant_idx;
            burst_cnt_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register; LastGrant resets to the top index so requester 0 wins first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(pNumReq - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_nxt;
      grant_q      <= grant_nxt;
      last_grant_q <= last_grant_nxt;
      burst_cnt_q  <= burst_cnt_nxt;
    end
  end

  assign Grant     = grant_q;
  assign Busy      = (state_q == ST_BURST);
  assign ReqReady  = grant_q & {pNumReq{~PushFull}};
  assign PushReq_n = ~xfer;
  assign PushData  = data_mux;

endmodule
`default_nettype wire

// File: tb/tb_cr_fifo_push_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_fifo_push_arb
// Purpose  : Directed, table-driven bench for cr_fifo_push_arb (4 requesters,
//            8-bit data, bursts of 4). Each table row gives the inputs for
//            one cycle and the outputs expected in that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_fifo_push_arb;

  logic        Clk;
  logic        Rst_n;
  logic [3:0]  ReqValid;
  logic [3:0]  ReqLast;
  logic [31:0] ReqData;
  logic [3:0]  ReqReady;
  logic        PushFull;
  logic        PushReq_n;
  logic [7:0]  PushData;
  logic [3:0]  Grant;
  logic        Busy;

  cr_fifo_push_arb #(
    .pNumReq   (4),
    .pDataWidth(8),
    .pMaxBurst (4)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .ReqValid (ReqValid),
    .ReqLast  (ReqLast),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .PushFull (PushFull),
    .PushReq_n(PushReq_n),
    .PushData (PushData),
    .Grant    (Grant),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  e_grant;
    logic [3:0]  e_ready;
    logic        e_push_n;
    logic [7:0]  e_pdata;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic v(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                   input logic full, input logic [31:0] data, input logic [3:0] g,
                   input logic [3:0] r, input logic pn, input logic [7:0] pd, input logic b);
    vec_t t;
    t.rst = rst; t.valid = valid; t.last = last; t.full = full; t.data = data;
    t.e_grant = g; t.e_ready = r; t.e_push_n = pn; t.e_pdata = pd; t.e_busy = b;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  task automatic do_reset();
    ReqValid = '0; ReqLast = '0; PushFull = 1'b0; ReqData = '0;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- table ----------------
    //  rst valid    last     full data           grant    ready    pn    pd     busy
    // Single requester, 6 words, last on word 6, bursts of 4
    v(1, 4'b0001, 4'b0000, 0, 32'h0000_0001, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0001, 4'b0001, 4'b0001, 0, 8'h01, 1);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0002, 4'b0001, 4'b0001, 0, 8'h02, 1);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0003, 4'b0001, 4'b0001, 0, 8'h03, 1);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0004, 4'b0001, 4'b0001, 0, 8'h04, 1);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0005, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0001, 4'b0000, 0, 32'h0000_0005, 4'b0001, 4'b0001, 0, 8'h05, 1);
    v(0, 4'b0001, 4'b0001, 0, 32'h0000_0006, 4'b0001, 4'b0001, 0, 8'h06, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    // Round robin: all valid, last on every word -> 0,1,2,3,0
    v(1, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0001, 4'b0001, 0, 8'h11, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0010, 4'b0010, 0, 8'h22, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0100, 4'b0100, 0, 8'h33, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b1000, 4'b1000, 0, 8'h44, 1);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b1111, 4'b1111, 0, 32'h4433_2211, 4'b0001, 4'b0001, 0, 8'h11, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    // Full in IDLE: no grant until full falls
    v(0, 4'b0100, 4'b0000, 1, 32'h00A1_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0100, 4'b0000, 1, 32'h00A1_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0100, 4'b0000, 0, 32'h00A1_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    // Full stall mid-burst for requester 2
    v(0, 4'b0100, 4'b0000, 0, 32'h00A1_0000, 4'b0100, 4'b0100, 0, 8'hA1, 1);
    v(0, 4'b0100, 4'b0000, 0, 32'h00A2_0000, 4'b0100, 4'b0100, 0, 8'hA2, 1);
    v(0, 4'b0100, 4'b0000, 1, 32'h00A3_0000, 4'b0100, 4'b0000, 1, 8'hA3, 1);
    v(0, 4'b0100, 4'b0000, 1, 32'h00A3_0000, 4'b0100, 4'b0000, 1, 8'hA3, 1);
    v(0, 4'b0100, 4'b0000, 1, 32'h00A3_0000, 4'b0100, 4'b0000, 1, 8'hA3, 1);
    v(0, 4'b0100, 4'b0000, 0, 32'h00A3_0000, 4'b0100, 4'b0100, 0, 8'hA3, 1);
    v(0, 4'b0100, 4'b0000, 0, 32'h00A4_0000, 4'b0100, 4'b0100, 0, 8'hA4, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    // Abandon: requester 1 drops valid after 2 words, requester 2 then wins
    v(0, 4'b0010, 4'b0000, 0, 32'h0000_B100, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0010, 4'b0000, 0, 32'h0000_B100, 4'b0010, 4'b0010, 0, 8'hB1, 1);
    v(0, 4'b0010, 4'b0000, 0, 32'h0000_B200, 4'b0010, 4'b0010, 0, 8'hB2, 1);
    v(0, 4'b0100, 4'b0000, 0, 32'h00C1_0000, 4'b0010, 4'b0010, 1, 8'h00, 1);
    v(0, 4'b0100, 4'b0000, 0, 32'h00C1_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);
    v(0, 4'b0100, 4'b0100, 0, 32'h00C1_0000, 4'b0100, 4'b0100, 0, 8'hC1, 1);
    v(0, 4'b0000, 4'b0000, 0, 32'h0000_0000, 4'b0000, 4'b0000, 1, 8'h00, 0);

    // ---------------- reset state ----------------
    Rst_n = 1'b0;
    ReqValid = 4'b1111; ReqLast = '0; PushFull = 1'b0; ReqData = 32'h4433_2211;
    @(posedge Clk);
    #1;
    chk("reset_grant",  {28'd0, Grant},     32'h0);
    chk("reset_busy",   {31'd0, Busy},      32'h0);
    chk("reset_ready",  {28'd0, ReqReady},  32'h0);
    chk("reset_push_n", {31'd0, PushReq_n}, 32'h1);
    chk("reset_pdata",  {24'd0, PushData},  32'h0);

    // ---------------- table run ----------------
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      ReqValid = vq[i].valid;
      ReqLast  = vq[i].last;
      PushFull = vq[i].full;
      ReqData  = vq[i].data;
      #1;
      n_checks++;
      if (Grant === vq[i].e_grant && ReqReady === vq[i].e_ready &&
          PushReq_n === vq[i].e_push_n && PushData === vq[i].e_pdata &&
          Busy === vq[i].e_busy) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d: got grant=%b ready=%b push_n=%b pdata=%h busy=%b, required grant=%b ready=%b push_n=%b pdata=%h busy=%b",
                 i, Grant, ReqReady, PushReq_n, PushData, Busy,
                 vq[i].e_grant, vq[i].e_ready, vq[i].e_push_n, vq[i].e_pdata, vq[i].e_busy);
      end
      @(posedge Clk);
      #1;
    end

    // ---------------- async reset mid-burst ----------------
    do_reset();
    ReqValid = 4'b0100; ReqData = 32'h00D1_0000;
    @(posedge Clk);
    #1;
    chk("ar_grant_pre", {28'd0, Grant}, 32'h4);
    chk("ar_busy_pre",  {31'd0, Busy},  32'h1);
    #3;
    Rst_n = 1'b0;
    #1;
    chk("ar_grant",  {28'd0, Grant},     32'h0);
    chk("ar_busy",   {31'd0, Busy},      32'h0);
    chk("ar_ready",  {28'd0, ReqReady},  32'h0);
    chk("ar_push_n", {31'd0, PushReq_n}, 32'h1);
    #2;
    Rst_n = 1'b1;
    ReqValid = 4'b1010; ReqData = 32'h00D1_E200;
    @(posedge Clk);
    #1;
    chk("ar_regrant",    {28'd0, Grant},     32'h2);
    chk("ar_reg_push_n", {31'd0, PushReq_n}, 32'h0);
    chk("ar_reg_pdata",  {24'd0, PushData},  32'hE2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
